// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared widths and types for the register file and the ALU
//             status-flag register.
//  Contents : kRF_W / kRF_A default data and address widths, data_t,
//             raddr_t, flags_t (carry/shift bit + zero bit).
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int kRF_W = 8;
  localparam int kRF_A = 3;

  typedef logic [kRF_W-1:0] data_t;
  typedef logic [kRF_A-1:0] raddr_t;

  typedef struct packed {
    logic sc;
    logic z;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_alu_flag_reg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flag_reg
//  Purpose  : Holds the ALU status flags (carry/shift bit and zero bit).
//             Each flag loads independently when its enable is set and
//             otherwise holds. Cleared asynchronously by reset.
//  Ports    : clk    in  rising-edge clock
//             reset  in  asynchronous active-high clear
//             en     in  per-flag load enables
//             d      in  per-flag next values
//             q      out stored flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flag_reg
  import reg_file_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  flags_t en,
  input  flags_t d,
  output flags_t q
);

  flags_t r_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      if (en.sc) r_flags.sc <= d.sc;
      if (en.z)  r_flags.z  <= d.z;
    end
  end

  assign q = r_flags;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : Architectural register file plus ALU status flags, feeding the
//             ALU operand inputs and carry-in. Two combinational read ports,
//             one write-back port, optional same-cycle write bypass and an
//             optional hard-wired zero register 0.
//  Ports    : clk             in  rising-edge clock
//             reset           in  asynchronous active-high reset
//             ra_addr/rb_addr in  read port addresses
//             wr_en/wr_addr/wr_data in write-back port
//             sc_wen/sc_d     in  carry/shift flag load
//             z_wen/z_d       in  zero flag load
//             data_a/data_b   out read data (ALU INPUTA / INPUTB)
//             sc_q            out stored carry/shift flag (ALU SC_IN)
//             z_q             out stored zero flag (branch logic)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file
  import reg_file_pkg::*;
#(
  parameter int W       = kRF_W,
  parameter int A       = kRF_A,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [A-1:0] ra_addr,
  input  logic [A-1:0] rb_addr,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         sc_wen,
  input  logic         sc_d,
  input  logic         z_wen,
  input  logic         z_d,
  output logic [W-1:0] data_a,
  output logic [W-1:0] data_b,
  output logic         sc_q,
  output logic         z_q
);

  localparam int c_DEPTH = 1 << A;

  logic [W-1:0] r_regs [c_DEPTH];
  logic         w_wr_ok;
  logic         w_byp_ok;
  flags_t       w_flag_en;
  flags_t       w_flag_d;
  flags_t       w_flag_q;

  // Writes to register 0 are discarded when it is hard-wired to zero.
  assign w_wr_ok  = wr_en && !((R0_ZERO != 0) && (wr_addr == '0));
  // Bypass is suppressed during reset so both ports read zero while it is held.
  assign w_byp_ok = (BYPASS != 0) && w_wr_ok && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    data_a = r_regs[ra_addr];
    if (w_byp_ok && (wr_addr == ra_addr)) data_a = wr_data;
    if ((R0_ZERO != 0) && (ra_addr == '0)) data_a = '0;
  end

  always_comb begin
    data_b = r_regs[rb_addr];
    if (w_byp_ok && (wr_addr == rb_addr)) data_b = wr_data;
    if ((R0_ZERO != 0) && (rb_addr == '0)) data_b = '0;
  end

  // Flags are never bypassed: the ALU always sees the stored carry, so a
  // multi-byte operation chains one byte per cycle.
  assign w_flag_en = '{sc: sc_wen, z: z_wen};
  assign w_flag_d  = '{sc: sc_d,   z: z_d};

  alu_flag_reg u_flags (
    .clk   (clk),
    .reset (reset),
    .en    (w_flag_en),
    .d     (w_flag_d),
    .q     (w_flag_q)
  );

  assign sc_q = w_flag_q.sc;
  assign z_q  = w_flag_q.z;

endmodule
`default_nettype wire
